// File: rtl/key_event_queue.sv
// key_event_queue
// Turns raw KeyboardDecoder output (held-key bitmap, last scan code, strobe)
// into press-only key events. Typematic repeats and releases are filtered
// by comparing the bitmap against its registered copy from the previous
// cycle. Each press is classified as a digit, space, enter or backspace and
// buffered in a small first-word-fall-through FIFO.
//
// Handshake: evt_valid is high whenever the FIFO holds at least one entry and
// evt_code then shows the oldest entry. An entry leaves the FIFO on a rising
// clk edge where evt_valid and evt_ready are both high and flush is low.
// evt_valid never depends on evt_ready, and evt_ready is ignored while empty.
module key_event_queue #(
    parameter int DEPTH     = 4,
    parameter bit KEYPAD_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [511:0]             key_down,
    input  logic [8:0]               last_change,
    input  logic                     key_valid,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [3:0]               evt_code,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ZERO = '0;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [511:0]   held_q, held_d;
    logic [3:0]     mem_q [DEPTH];
    logic [3:0]     mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           evt_valid_q, evt_valid_d;
    logic [3:0]     evt_code_q, evt_code_d;

    // ------------------------------------------------------------------
    // Combinational decode signals
    // ------------------------------------------------------------------
    logic           cls_hit;
    logic [3:0]     cls_code;
    logic           press;
    logic           push;
    logic           pop;
    logic           full;
    logic           do_write;

    // Previous-cycle copy of the bitmap; tracked even while en is low so a
    // key pressed during en=0 is still seen as held afterwards.
    always_comb begin
        held_d = key_down;
    end

    // A press is a make strobe for a key that was not held last cycle.
    always_comb begin
        press = key_valid & key_down[last_change] & ~held_q[last_change];
    end

    // Map the scan code to an event code; unlisted codes are unclassified.
    always_comb begin
        cls_hit  = 1'b0;
        cls_code = 4'd0;
        case (last_change)
            // Main-row digits 0..9
            9'h045: begin cls_hit = 1'b1; cls_code = 4'd0;  end
            9'h016: begin cls_hit = 1'b1; cls_code = 4'd1;  end
            9'h01E: begin cls_hit = 1'b1; cls_code = 4'd2;  end
            9'h026: begin cls_hit = 1'b1; cls_code = 4'd3;  end
            9'h025: begin cls_hit = 1'b1; cls_code = 4'd4;  end
            9'h02E: begin cls_hit = 1'b1; cls_code = 4'd5;  end
            9'h036: begin cls_hit = 1'b1; cls_code = 4'd6;  end
            9'h03D: begin cls_hit = 1'b1; cls_code = 4'd7;  end
            9'h03E: begin cls_hit = 1'b1; cls_code = 4'd8;  end
            9'h046: begin cls_hit = 1'b1; cls_code = 4'd9;  end
            // Numeric keypad digits 0..9, only when the keypad is enabled
            9'h070: begin cls_hit = KEYPAD_EN; cls_code = 4'd0; end
            9'h069: begin cls_hit = KEYPAD_EN; cls_code = 4'd1; end
            9'h072: begin cls_hit = KEYPAD_EN; cls_code = 4'd2; end
            9'h07A: begin cls_hit = KEYPAD_EN; cls_code = 4'd3; end
            9'h06B: begin cls_hit = KEYPAD_EN; cls_code = 4'd4; end
            9'h073: begin cls_hit = KEYPAD_EN; cls_code = 4'd5; end
            9'h074: begin cls_hit = KEYPAD_EN; cls_code = 4'd6; end
            9'h06C: begin cls_hit = KEYPAD_EN; cls_code = 4'd7; end
            9'h075: begin cls_hit = KEYPAD_EN; cls_code = 4'd8; end
            9'h07D: begin cls_hit = KEYPAD_EN; cls_code = 4'd9; end
            // Editing keys; enter exists on the main block and the keypad
            9'h029: begin cls_hit = 1'b1; cls_code = 4'd10; end
            9'h05A: begin cls_hit = 1'b1; cls_code = 4'd11; end
            9'h15A: begin cls_hit = 1'b1; cls_code = 4'd11; end
            9'h066: begin cls_hit = 1'b1; cls_code = 4'd12; end
            default: begin cls_hit = 1'b0; cls_code = 4'd0; end
        endcase
    end

    // FIFO next state: flush wins, then push/pop with full-case handling.
    // The registered head/valid are derived from the next state so the
    // outputs have no combinational path from the key inputs.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        full        = (count_q == CNT_FULL);
        push        = press & en & cls_hit & ~flush;
        pop         = evt_valid_q & evt_ready & ~flush;
        do_write    = 1'b0;

        if (flush) begin
            wr_ptr_d   = PTR_ZERO;
            rd_ptr_d   = PTR_ZERO;
            count_d    = CNT_ZERO;
            overflow_d = 1'b0;
        end else begin
            // When full, a simultaneous pop frees the slot being written.
            do_write = push & (~full | pop);

            if (push & full & ~pop) begin
                overflow_d = 1'b1;
            end

            if (do_write) begin
                mem_d[wr_ptr_q] = cls_code;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            case ({do_write, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        evt_valid_d = (count_d != CNT_ZERO);
        evt_code_d  = evt_valid_d ? mem_d[rd_ptr_d] : 4'd0;
    end

    // Held-key shadow register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q <= '0;
        end else begin
            held_q <= held_d;
        end
    end

    // FIFO storage, pointers, count, sticky overflow and registered head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 4'd0;
            end
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            overflow_q  <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= 4'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
        end
    end

    // Drive outputs straight from registers.
    always_comb begin
        evt_valid = evt_valid_q;
        evt_code  = evt_code_q;
        evt_count = count_q;
        overflow  = overflow_q;
    end

endmodule
